// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register-file write/read port logic.
package regfile_pkg;

   localparam int NREGS    = 32;
   localparam int REGNUM_W = 5;
   localparam int DATA_W   = 32;
   localparam logic [REGNUM_W-1:0] ZERO_REG = 5'd0;

   function automatic logic [NREGS-1:0] onehot_decode(input logic [REGNUM_W-1:0] regnum);
      logic [NREGS-1:0] vec;
      vec         = '0;
      vec[regnum] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr_i,
// wrapping modulo NUM_REQ.
module rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] elig_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [PTR_W-1:0]   winner_o,
   output logic               any_o
);

   always_comb begin
      int               idx;
      logic [PTR_W-1:0] idxSel;
      logic             found;
      winner_o = '0;
      any_o    = 1'b0;
      idx      = 0;
      idxSel   = '0;
      found    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr_i) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         idxSel = PTR_W'(idx);
         if (!found && elig_i[idxSel]) begin
            found    = 1'b1;
            winner_o = idxSel;
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// NUM_REQ writeback sources; writes to register 0 are granted but discarded.
module regfile_write_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 32,
   parameter int NREGS   = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*5-1:0]      regnum,
   input  logic [NUM_REQ*DATA_W-1:0] d,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NREGS-1:0]          wr_enable,
   output logic [4:0]                wr_regnum,
   output logic [DATA_W-1:0]         wr_data,
   output logic                      busy
);
   import regfile_pkg::*;

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]  gnt_q, gnt_d, elig;
   logic [NREGS-1:0]    wr_enable_q, wr_enable_d;
   logic [REGNUM_W-1:0] wr_regnum_q, wr_regnum_d, selRegnum;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d, selData;
   logic [PTR_W-1:0]    ptr_q, ptr_d, winIdx;
   logic                winAny;

   // Last cycle's grant masks its owner so it can drop or update req in time.
   assign elig = req & ~gnt_q;
   assign busy = |elig;

   rr_pick #(
      .NUM_REQ(NUM_REQ),
      .PTR_W  (PTR_W)
   ) u_pick (
      .elig_i  (elig),
      .ptr_i   (ptr_q),
      .winner_o(winIdx),
      .any_o   (winAny)
   );

   always_comb begin
      selRegnum = '0;
      selData   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (int'(winIdx) == i) begin
            selRegnum = regnum[i*REGNUM_W +: REGNUM_W];
            selData   = d[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      gnt_d       = '0;
      wr_enable_d = '0;
      wr_regnum_d = wr_regnum_q;
      wr_data_d   = wr_data_q;
      ptr_d       = ptr_q;
      if (winAny) begin
         gnt_d[winIdx] = 1'b1;
         wr_regnum_d   = selRegnum;
         wr_data_d     = selData;
         if (selRegnum != ZERO_REG) wr_enable_d = onehot_decode(selRegnum);
         ptr_d = (int'(winIdx) == NUM_REQ - 1) ? '0 : winIdx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         gnt_q       <= '0;
         wr_enable_q <= '0;
         wr_regnum_q <= '0;
         wr_data_q   <= '0;
         ptr_q       <= '0;
      end else begin
         gnt_q       <= gnt_d;
         wr_enable_q <= wr_enable_d;
         wr_regnum_q <= wr_regnum_d;
         wr_data_q   <= wr_data_d;
         ptr_q       <= ptr_d;
      end
   end

   assign gnt       = gnt_q;
   assign wr_enable = wr_enable_q;
   assign wr_regnum = wr_regnum_q;
   assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scoreboard bench for regfile_write_arbiter with a behavioural
// register array hung off the write port.
module tb_regfile_write_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req;
   logic [9:0]  regnum;
   logic [63:0] d;
   logic [1:0]  gnt;
   logic [31:0] wr_enable;
   logic [4:0]  wr_regnum;
   logic [31:0] wr_data;
   logic        busy;

   typedef struct {
      string       tag;
      logic [1:0]  gnt;
      logic [31:0] en;
      logic [4:0]  rn;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          passCount  = 0;
   int          failCount  = 0;
   int          checkCount = 0;
   logic [31:0] regArr[32];

   regfile_write_arbiter #(
      .NUM_REQ(2),
      .DATA_W (32),
      .NREGS  (32)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .regnum   (regnum),
      .d        (d),
      .gnt      (gnt),
      .wr_enable(wr_enable),
      .wr_regnum(wr_regnum),
      .wr_data  (wr_data),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Stand-in for the array of register instances fed by the write port.
   always @(posedge clk) begin
      for (int i = 0; i < 32; i++) begin
         if (!reset) regArr[i] <= '0;
         else if (wr_enable[i]) regArr[i] <= wr_data;
      end
   end

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input string tag, input logic rstN, input logic [1:0] r,
                                input logic [4:0] rn0, input logic [31:0] d0,
                                input logic [4:0] rn1, input logic [31:0] d1,
                                input logic [1:0] eGnt, input logic [31:0] eEn,
                                input logic [4:0] eRn, input logic [31:0] eData);
      exp_t e;
      reset  = rstN;
      req    = r;
      regnum = {rn1, rn0};
      d      = {d1, d0};
      e.tag  = tag;
      e.gnt  = eGnt;
      e.en   = eEn;
      e.rn   = eRn;
      e.data = eData;
      sb.push_back(e);
   endtask

   task automatic checkBusy(input string tag, input logic exp);
      #1;
      checkVal(tag, 64'(busy), 64'(exp));
   endtask

   task automatic checkOutput();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checkCount++;
         failCount++;
         $error("[TB] FAIL sb_empty: observed no expectation required one");
      end else begin
         e = sb.pop_front();
         checkVal({e.tag, ".gnt"}, 64'(gnt), 64'(e.gnt));
         checkVal({e.tag, ".wr_enable"}, 64'(wr_enable), 64'(e.en));
         checkVal({e.tag, ".wr_regnum"}, 64'(wr_regnum), 64'(e.rn));
         checkVal({e.tag, ".wr_data"}, 64'(wr_data), 64'(e.data));
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      applyStimulus("rst0", 1'b0, 2'b11, 5'd1, 32'd11, 5'd2, 32'd22, 2'b00, 32'h0, 5'd0, 32'd0);
      checkOutput();
      applyStimulus("rst1", 1'b0, 2'b11, 5'd1, 32'd11, 5'd2, 32'd22, 2'b00, 32'h0, 5'd0, 32'd0);
      checkOutput();
      applyStimulus("rel_g0", 1'b1, 2'b11, 5'd1, 32'd11, 5'd2, 32'd22, 2'b01, 32'h2, 5'd1, 32'd11);
      checkOutput();
      applyStimulus("rel_g1", 1'b1, 2'b11, 5'd1, 32'd11, 5'd2, 32'd22, 2'b10, 32'h4, 5'd2, 32'd22);
      checkBusy("busy_pair", 1'b1);
      checkOutput();
      applyStimulus("idle_hold", 1'b1, 2'b00, 5'd1, 32'd11, 5'd2, 32'd22, 2'b00, 32'h0, 5'd2, 32'd22);
      checkBusy("busy_idle", 1'b0);
      checkOutput();

      applyStimulus("sw_grant", 1'b1, 2'b01, 5'd5, 32'd88, 5'd2, 32'd22, 2'b01, 32'h20, 5'd5, 32'd88);
      checkBusy("busy_sw", 1'b1);
      checkOutput();
      applyStimulus("sw_mask", 1'b1, 2'b01, 5'd5, 32'd88, 5'd2, 32'd22, 2'b00, 32'h0, 5'd5, 32'd88);
      checkBusy("busy_masked", 1'b0);
      checkOutput();
      checkVal("reg5_q", 64'(regArr[5]), 64'd88);
      applyStimulus("sw_idle", 1'b1, 2'b00, 5'd5, 32'd88, 5'd2, 32'd22, 2'b00, 32'h0, 5'd5, 32'd88);
      checkOutput();

      applyStimulus("z_grant", 1'b1, 2'b10, 5'd5, 32'd88, 5'd0, 32'hDEAD, 2'b10, 32'h0, 5'd0, 32'hDEAD);
      checkOutput();
      applyStimulus("z_idle", 1'b1, 2'b00, 5'd5, 32'd88, 5'd0, 32'hDEAD, 2'b00, 32'h0, 5'd0, 32'hDEAD);
      checkOutput();
      checkVal("reg0_q", 64'(regArr[0]), 64'd0);

      // Pointer is back at 0, so continuous contention must start with requester 0.
      for (int k = 0; k < 5; k++) begin
         if (k % 2 == 0)
            applyStimulus($sformatf("cont%0d", k), 1'b1, 2'b11, 5'd3, 32'd89, 5'd4, 32'd90,
                          2'b01, 32'h8, 5'd3, 32'd89);
         else
            applyStimulus($sformatf("cont%0d", k), 1'b1, 2'b11, 5'd3, 32'd89, 5'd4, 32'd90,
                          2'b10, 32'h10, 5'd4, 32'd90);
         checkOutput();
      end
      applyStimulus("cont_idle", 1'b1, 2'b00, 5'd3, 32'd89, 5'd4, 32'd90, 2'b00, 32'h0, 5'd3, 32'd89);
      checkOutput();
      checkVal("reg3_q", 64'(regArr[3]), 64'd89);
      checkVal("reg4_q", 64'(regArr[4]), 64'd90);

      applyStimulus("col_g1", 1'b1, 2'b11, 5'd7, 32'd1, 5'd7, 32'd2, 2'b10, 32'h80, 5'd7, 32'd2);
      checkOutput();
      applyStimulus("col_g0", 1'b1, 2'b11, 5'd7, 32'd1, 5'd7, 32'd2, 2'b01, 32'h80, 5'd7, 32'd1);
      checkOutput();
      applyStimulus("col_idle", 1'b1, 2'b00, 5'd7, 32'd1, 5'd7, 32'd2, 2'b00, 32'h0, 5'd7, 32'd1);
      checkOutput();
      checkVal("reg7_q", 64'(regArr[7]), 64'd1);

      applyStimulus("rm_grant", 1'b1, 2'b01, 5'd9, 32'd55, 5'd10, 32'd66, 2'b01, 32'h200, 5'd9, 32'd55);
      checkOutput();
      applyStimulus("rm_reset", 1'b0, 2'b01, 5'd9, 32'd55, 5'd10, 32'd66, 2'b00, 32'h0, 5'd0, 32'd0);
      checkOutput();
      applyStimulus("rm_regrant", 1'b1, 2'b11, 5'd9, 32'd55, 5'd10, 32'd66, 2'b01, 32'h200, 5'd9, 32'd55);
      checkOutput();
      applyStimulus("rm_next", 1'b1, 2'b11, 5'd9, 32'd55, 5'd10, 32'd66, 2'b10, 32'h400, 5'd10, 32'd66);
      checkOutput();
      req = 2'b00;

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32 x 32-bit register file (an array of `register` instances, each with `q, d, clk, enable, reset`) between NUM_REQ requesters.
- Arbitrates round-robin and drives the file's per-register one-hot enables plus a shared data bus.
- Suppresses writes to register 0.
- Sits between the writeback sources (e.g. ALU result, load return) and the register array.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- DATA_W, 32, data width.
- NREGS, 32, number of registers; regnum width is log2(NREGS) = 5.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; 0 at a rising clk edge clears the block
- req  in  NUM_REQ  per-requester write request; held high until granted
- regnum  in  NUM_REQ*5  packed target register numbers; requester i occupies bits [5i+4:5i]
- d  in  NUM_REQ*DATA_W  packed write data; requester i occupies bits [DATA_W*i+DATA_W-1:DATA_W*i]
- gnt  out  NUM_REQ  one-cycle grant pulse, registered
- wr_enable  out  NREGS  one-hot enable to the register array, registered
- wr_regnum  out  5  granted register number, registered, for debug and forwarding
- wr_data  out  DATA_W  data bus to the `d` inputs of every register, registered
- busy  out  1  high when any unmasked req is pending this cycle (combinational)

Behaviour:
- Reset (reset=0 at an edge) clears the outputs and the pointer:
  - gnt=0, wr_enable=0, wr_regnum=0, wr_data=0.
  - Round-robin pointer ptr=0, so requester 0 has priority first.
  - Mask register cleared.
- Reset wins over any simultaneous req. A request pending during reset is dropped, not queued. The requester keeps req high, so it is re-arbitrated after reset releases.
- Eligibility:
  - elig[i] = req[i] & ~gnt[i].
  - The gnt register doubles as the mask. A requester granted in the previous cycle is ineligible this cycle, so it has one cycle to drop or update req without being granted twice.
- Arbitration:
  - Combinational search of elig starting at index ptr, wrapping modulo NUM_REQ. The first set bit is the winner w.
- Rising edge with reset=1 and some elig bit set:
  - gnt <= one-hot(w).
  - wr_regnum <= regnum[w], wr_data <= d[w].
  - wr_enable <= one-hot(regnum[w]), except all zeros when regnum[w]==0.
  - ptr <= (w+1) mod NUM_REQ.
- Rising edge with reset=1 and no elig bit set: gnt <= 0, wr_enable <= 0; wr_data, wr_regnum and ptr hold.
- Latency:
  - req sampled at edge N; gnt, wr_enable and wr_data valid from edge N+1 for exactly one cycle.
  - The register array latches at edge N+2, so the new value appears on q after edge N+2.
- Register-0 writes:
  - Still granted; gnt pulses normally and ptr advances.
  - wr_enable stays zero, so the write is discarded silently.
- Throughput:
  - One write per cycle when at least two requesters alternate.
  - A lone requester gets at most one grant every 2 cycles, because of the mask.
- Same target register from two requesters: they are serialised by round-robin and the later grant's data persists. No merging.
- Regnum and data must be stable while req is high; the block captures them only at the grant edge.
- No X propagation: all outputs are defined from the first post-reset edge.

Decomposition:
- Shared package `regfile_pkg`:
  - constants NREGS=32, REGNUM_W=5, DATA_W=32, ZERO_REG=5'd0
  - function onehot_decode(regnum) returning NREGS bits
- One sub-module: `rr_pick`, the combinational round-robin priority picker.
  - Inputs: elig[NUM_REQ], ptr.
  - Outputs: winner index, any.
  - Reused later by the read-port scheduler.

Test Plan:
- Reset sequence:
  - Hold reset=0 for 2 edges with req=2'b11.
  - All outputs stay 0 and no gnt appears.
  - Release reset; the first grant goes to requester 0 (ptr=0).
- Single writer:
  - req0=1, regnum0=5, d0=88, held 1 cycle after gnt.
  - gnt0 pulses once at N+1, wr_enable=32'h20, wr_data=88.
  - Register 5 q=88 after N+2.
  - No second grant during the mask cycle.
- Contention:
  - Both requests held continuously: req0 targets reg 3 with d=89, req1 targets reg 4 with d=90.
  - Grants alternate 0,1,0,1 on consecutive cycles.
  - wr_enable alternates 32'h8 / 32'h10.
- Zero-register drop:
  - req1=1, regnum1=0, d1=32'hDEAD.
  - gnt1 pulses, wr_enable=0.
  - Register 0 q stays 0 and ptr advances to 0.
- Same-target collision:
  - Both requesters target reg 7 in the same cycle, ptr=1, with d1=2 and d0=1.
  - Requester 1 is granted first, then requester 0.
  - Final q of register 7 is 1.
- Reset mid-operation:
  - Assert reset=0 in the cycle gnt0 is high.
  - At the next edge all outputs are 0 and ptr=0.
  - The held req0 is re-granted 1 cycle after reset releases.
